// File: rtl/polar_convert_arbiter.sv
// Three-requester arbiter sharing one combinational polar_to_cartesian converter.
// Build option: define POLAR_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).

// Angle index in 15 degree steps (0..11) and 8-bit radius to rounded two's-complement x/y.
module polar_to_cartesian (
  input  logic [11:0] theta_i,
  output logic [8:0]  x_o,
  output logic [8:0]  y_o,
  output logic        err_o
);

  localparam int unsigned FracW = 24;
  localparam int unsigned ProdW = 33;

  logic [3:0] angle;
  logic [7:0] radius;

  assign angle  = theta_i[11:8];
  assign radius = theta_i[7:0];

  // sin(n*15 deg) in Q24, n = 0..6
  function automatic logic [24:0] sin_coef(input logic [2:0] n);
    case (n)
      3'd0:    sin_coef = 25'd0;
      3'd1:    sin_coef = 25'd4342263;
      3'd2:    sin_coef = 25'd8388608;
      3'd3:    sin_coef = 25'd11863283;
      3'd4:    sin_coef = 25'd14529495;
      3'd5:    sin_coef = 25'd16205546;
      default: sin_coef = 25'd16777216;
    endcase
  endfunction

  // Magnitude rounded half away from zero; never exceeds 255
  function automatic logic [8:0] scale(input logic [7:0] r, input logic [24:0] c);
    logic [32:0] p;
    p = ProdW'(r) * ProdW'(c) + ProdW'(24'h800000);
    scale = 9'(p >> FracW);
  endfunction

  always_comb begin
    x_o   = 9'd0;
    y_o   = 9'd0;
    err_o = 1'b0;
    if (angle > 4'd11) begin
      err_o = 1'b1;
    end else if (angle <= 4'd6) begin
      x_o = scale(radius, sin_coef(3'(4'd6 - angle)));
      y_o = scale(radius, sin_coef(angle[2:0]));
    end else begin
      x_o = 9'd0 - scale(radius, sin_coef(3'(angle - 4'd6)));
      y_o = scale(radius, sin_coef(3'(4'd12 - angle)));
    end
  end

endmodule

module polar_convert_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [11:0] r_theta0,
  input  logic [11:0] r_theta1,
  input  logic [11:0] r_theta2,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        out_valid,
  output logic [8:0]  out_x,
  output logic [8:0]  out_y,
  output logic [1:0]  out_tag,
  output logic        out_err
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [11:0]     operand_q, operand_d;
  logic [1:0]      tag_q, tag_d;
  logic [2:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [8:0]      x_q, x_d, y_q, y_d;
  logic [1:0]      out_tag_q, out_tag_d;
  logic            err_q, err_d;

  logic        any_req;
  logic [1:0]  sel_idx;
  logic [11:0] sel_theta;
  logic [8:0]  conv_x, conv_y;
  logic        conv_err;

  polar_to_cartesian u_conv (
    .theta_i (operand_q),
    .x_o     (conv_x),
    .y_o     (conv_y),
    .err_o   (conv_err)
  );

`ifdef POLAR_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Search from the requester after the last grant; lowest offset wins
  always_comb begin : arb
    logic [1:0] start;
    logic [2:0] sum;
    any_req = 1'b0;
    sel_idx = 2'd0;
    start   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    sum     = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      sum = {1'b0, start} + 3'(i);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (req[sum[1:0]]) begin
        any_req = 1'b1;
        sel_idx = sum[1:0];
      end
    end
  end
`else
  always_comb begin : arb
    any_req = |req;
    sel_idx = 2'd0;
    if (req[0])      sel_idx = 2'd0;
    else if (req[1]) sel_idx = 2'd1;
    else if (req[2]) sel_idx = 2'd2;
  end
`endif

  always_comb begin
    case (sel_idx)
      2'd0:    sel_theta = r_theta0;
      2'd1:    sel_theta = r_theta1;
      default: sel_theta = r_theta2;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    tag_d     = tag_q;
    grant_d   = 3'b000;
    valid_d   = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    out_tag_d = out_tag_q;
    err_d     = err_q;
`ifdef POLAR_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          operand_d = sel_theta;
          tag_d     = sel_idx;
          grant_d   = 3'b001 << sel_idx;
          cnt_d     = '0;
          state_d   = SETTLE;
`ifdef POLAR_ARB_ROUND_ROBIN_EN
          ptr_d     = sel_idx;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          x_d       = conv_x;
          y_d       = conv_y;
          err_d     = conv_err;
          out_tag_d = tag_q;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      operand_q <= '0;
      tag_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      out_tag_q <= '0;
      err_q     <= 1'b0;
`ifdef POLAR_ARB_ROUND_ROBIN_EN
      ptr_q     <= 2'd2;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      tag_q     <= tag_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      out_tag_q <= out_tag_d;
      err_q     <= err_d;
`ifdef POLAR_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_tag   = out_tag_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_polar_convert_arbiter.sv
// Scoreboard bench for polar_convert_arbiter with SETTLE_CYCLES = 2.
module tb_polar_convert_arbiter;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] tag;
    logic       err;
  } res_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [11:0] r_theta0, r_theta1, r_theta2;
  logic [2:0]  grant;
  logic        busy, out_valid;
  logic [8:0]  out_x, out_y;
  logic [1:0]  out_tag;
  logic        out_err;

  int   nvec = 0;
  int   nerr = 0;
  res_t sb[$];
  res_t last_r;

  logic [11:0] th_tab [8] = '{12'h164, 12'hB64, 12'hC50, 12'h300,
                              12'h6FF, 12'h8C8, 12'h0FF, 12'h7FF};
  logic [1:0]  tg_tab [8] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

  polar_convert_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .r_theta0  (r_theta0),
    .r_theta1  (r_theta1),
    .r_theta2  (r_theta2),
    .grant     (grant),
    .busy      (busy),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [8:0] rnd(input real v);
    integer n;
    if (v >= 0.0) n = $rtoi($floor(v + 0.5 + 1.0e-9));
    else          n = -$rtoi($floor(-v + 0.5 + 1.0e-9));
    return 9'(n);
  endfunction

  // Reference conversion using real trigonometry
  function automatic res_t model(input logic [1:0] tag, input logic [11:0] th);
    res_t r;
    real  ang, rad;
    r.tag = tag;
    if (th[11:8] > 4'd11) begin
      r.x = 9'd0; r.y = 9'd0; r.err = 1'b1;
    end else begin
      ang = real'(th[11:8]) * 15.0 * 3.14159265358979 / 180.0;
      rad = real'(th[7:0]);
      r.x = rnd(rad * $cos(ang));
      r.y = rnd(rad * $sin(ang));
      r.err = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_theta(input logic [1:0] idx, input logic [11:0] th);
    case (idx)
      2'd0:    r_theta0 = th;
      2'd1:    r_theta1 = th;
      default: r_theta2 = th;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000;
    r_theta0 = '0; r_theta1 = '0; r_theta2 = '0;
    tick(); tick();
    nvec++;
    if ({grant, busy, out_valid, out_x, out_y, out_tag, out_err} !== 26'd0) begin
      nerr++;
      $display("FAIL reset_hold: got %h want 0", {grant, busy, out_valid, out_x, out_y, out_tag, out_err});
    end
    reset = 1'b0;
    tick();
    nvec++;
    if ({grant, busy, out_valid} !== 5'd0) begin
      nerr++;
      $display("FAIL idle_no_req: got %b want 00000", {grant, busy, out_valid});
    end
  endtask

  task automatic test_single();
    logic [2:0] oh;
    res_t got, exp_r;
    for (int i = 0; i < 8; i++) begin
      oh = 3'b001 << tg_tab[i];
      set_theta(tg_tab[i], th_tab[i]);
      req = oh;
      sb.push_back(model(tg_tab[i], th_tab[i]));
      tick();
      nvec++;
      if ({grant, busy} !== {oh, 1'b1}) begin
        nerr++;
        $display("FAIL single_grant[%0d]: got %b want %b", i, {grant, busy}, {oh, 1'b1});
      end
      req = 3'b000;
      tick();
      nvec++;
      if ({grant, out_valid} !== 4'b0000) begin
        nerr++;
        $display("FAIL single_gap[%0d]: got %b want 0000", i, {grant, out_valid});
      end
      tick();
      nvec++;
      if (out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL single_valid[%0d]: got %b want 1", i, out_valid);
      end
      exp_r = sb.pop_front();
      got = {out_x, out_y, out_tag, out_err};
      nvec++;
      if (got !== exp_r) begin
        nerr++;
        $display("FAIL single_result[%0d]: got x=%h y=%h tag=%0d err=%b want x=%h y=%h tag=%0d err=%b",
                 i, got.x, got.y, got.tag, got.err, exp_r.x, exp_r.y, exp_r.tag, exp_r.err);
      end
      last_r = exp_r;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if ({out_x, out_y, out_tag, out_err, out_valid, grant, busy} !== {last_r, 5'd0}) begin
        nerr++;
        $display("FAIL hold[%0d]: got %h want %h", i,
                 {out_x, out_y, out_tag, out_err, out_valid, grant, busy}, {last_r, 5'd0});
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0]  idx;
    logic [11:0] th;
    res_t got, exp_r;
    reset = 1'b1; tick(); reset = 1'b0;
    r_theta0 = 12'h164; r_theta1 = 12'h232; r_theta2 = 12'hB64;
    req = 3'b111;
    for (int n = 0; n < 3; n++) begin
`ifdef POLAR_ARB_ROUND_ROBIN_EN
      idx = 2'(n);
`else
      idx = 2'd0;
`endif
      th = (idx == 2'd0) ? r_theta0 : (idx == 2'd1) ? r_theta1 : r_theta2;
      sb.push_back(model(idx, th));
      tick();
      nvec++;
      if (grant !== (3'b001 << idx)) begin
        nerr++;
        $display("FAIL contention_grant[%0d]: got %b want %b", n, grant, 3'b001 << idx);
      end
      tick(); tick();
      nvec++;
      if (out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL contention_valid[%0d]: got %b want 1", n, out_valid);
      end
      exp_r = sb.pop_front();
      got = {out_x, out_y, out_tag, out_err};
      nvec++;
      if (got !== exp_r) begin
        nerr++;
        $display("FAIL contention_result[%0d]: got %h want %h", n, got, exp_r);
      end
    end
    req = 3'b000;
  endtask

  task automatic test_reset_mid();
    res_t got, exp_r;
    r_theta0 = 12'h164; req = 3'b001;
    tick();
    nvec++;
    if (grant !== 3'b001) begin
      nerr++;
      $display("FAIL abort_grant: got %b want 001", grant);
    end
    req = 3'b000; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({grant, busy, out_valid, out_x, out_y, out_tag, out_err} !== 26'd0) begin
        nerr++;
        $display("FAIL abort_quiet[%0d]: got %h want 0", i,
                 {grant, busy, out_valid, out_x, out_y, out_tag, out_err});
      end
      tick();
    end
    r_theta1 = 12'h232; req = 3'b010;
    sb.push_back(model(2'd1, 12'h232));
    tick();
    nvec++;
    if (grant !== 3'b010) begin
      nerr++;
      $display("FAIL after_abort_grant: got %b want 010", grant);
    end
    req = 3'b000;
    tick(); tick();
    exp_r = sb.pop_front();
    got = {out_x, out_y, out_tag, out_err};
    nvec++;
    if ({out_valid, got} !== {1'b1, exp_r}) begin
      nerr++;
      $display("FAIL after_abort_result: got %h want %h", {out_valid, got}, {1'b1, exp_r});
    end
  endtask

  task automatic test_stability();
    res_t got, exp_r;
    r_theta0 = 12'h164; req = 3'b001;
    sb.push_back(model(2'd0, 12'h164));
    tick();
    nvec++;
    if (grant !== 3'b001) begin
      nerr++;
      $display("FAIL stable_grant: got %b want 001", grant);
    end
    r_theta0 = 12'h000; req = 3'b110;
    tick();
    req = 3'b000;
    tick();
    exp_r = sb.pop_front();
    got = {out_x, out_y, out_tag, out_err};
    nvec++;
    if ({out_valid, got} !== {1'b1, exp_r}) begin
      nerr++;
      $display("FAIL stable_result: got %h want %h", {out_valid, got}, {1'b1, exp_r});
    end
    tick();
    nvec++;
    if ({grant, busy} !== 4'b0000) begin
      nerr++;
      $display("FAIL stable_idle: got %b want 0000", {grant, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] eg;
    logic       ev;
    res_t got, exp_r;
    r_theta1 = 12'h6FF; req = 3'b010;
    for (int c = 1; c <= 9; c++) begin
      if (c % 3 == 1) sb.push_back(model(2'd1, 12'h6FF));
      tick();
      eg = (c % 3 == 1) ? 3'b010 : 3'b000;
      ev = (c % 3 == 0);
      nvec++;
      if ({grant, out_valid} !== {eg, ev}) begin
        nerr++;
        $display("FAIL b2b_pulse[%0d]: got %b want %b", c, {grant, out_valid}, {eg, ev});
      end
      if (ev && out_valid === 1'b1 && sb.size() > 0) begin
        exp_r = sb.pop_front();
        got = {out_x, out_y, out_tag, out_err};
        nvec++;
        if (got !== exp_r) begin
          nerr++;
          $display("FAIL b2b_result[%0d]: got %h want %h", c, got, exp_r);
        end
      end
    end
    req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_contention();
    test_reset_mid();
    test_stability();
    test_back_to_back();
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
